// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one PicoRV32-native memory slave between two masters.
// Define MEM_ARB_TIMEOUT_EN to compile in the slave-hang timeout (TIMEOUT_CYCLES, sticky timeout_err).
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last;
    logic   sel0;
    logic   sel1;
    logic   own_valid;
    logic   timeout_hit;

    assign sel0      = (state == GRANT0);
    assign sel1      = (state == GRANT1);
    assign own_valid = (sel0 & m0_mem_valid) | (sel1 & m1_mem_valid);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_q;

    assign timeout_hit = (sel0 | sel1) & ~s_mem_ready & (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    // Counter is held at zero while idle, so it starts from zero on every grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE)
                wait_cnt <= '0;
            else if (!s_mem_ready)
                wait_cnt <= wait_cnt + 16'd1;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        s_mem_valid = 1'b0;
        s_mem_instr = 1'b0;
        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_wstrb = '0;
        if (sel0) begin
            s_mem_valid = m0_mem_valid;
            s_mem_instr = m0_mem_instr;
            s_mem_addr  = m0_mem_addr;
            s_mem_wdata = m0_mem_wdata;
            s_mem_wstrb = m0_mem_wstrb;
        end else if (sel1) begin
            s_mem_valid = m1_mem_valid;
            s_mem_instr = m1_mem_instr;
            s_mem_addr  = m1_mem_addr;
            s_mem_wdata = m1_mem_wdata;
            s_mem_wstrb = m1_mem_wstrb;
        end
        // A timed-out request is withdrawn from the slave in the same cycle it is answered.
        if (timeout_hit)
            s_mem_valid = 1'b0;
    end

    assign m0_mem_ready = sel0 & (s_mem_ready | timeout_hit);
    assign m1_mem_ready = sel1 & (s_mem_ready | timeout_hit);
    assign m0_mem_rdata = !sel0 ? '0 : (timeout_hit ? 32'hDEADBEEF : s_mem_rdata);
    assign m1_mem_rdata = !sel1 ? '0 : (timeout_hit ? 32'hDEADBEEF : s_mem_rdata);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (m0_mem_valid && (!m1_mem_valid || last)) begin
                        state <= GRANT0;
                        grant <= 2'b01;
                        last  <= 1'b0;
                    end else if (m1_mem_valid) begin
                        state <= GRANT1;
                        grant <= 2'b10;
                        last  <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (s_mem_ready || timeout_hit || !own_valid) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
